// File: rtl/sram_arbiter.sv
// Three-requester arbiter for a single-port SRAM: rotating priority, bounded hold
// time with forced preemption, one dead cycle between owners and a sticky write-without-grant flag.
module sram_arbiter #(
  parameter int          AW       = 18,
  parameter int          DW       = 16,
  parameter logic [15:0] MAX_HOLD = 16'd64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      req,
  output logic [2:0]      gnt,
  input  logic [3*AW-1:0] raddr_in,
  input  logic [3*AW-1:0] waddr_in,
  input  logic [3*DW-1:0] wdata_in,
  input  logic [2:0]      wr_en_in,
  output logic [AW-1:0]   sram_raddr,
  output logic [AW-1:0]   sram_waddr,
  output logic [DW-1:0]   sram_wdata,
  output logic            sram_wr_enable,
  input  logic [DW-1:0]   sram_rdata,
  output logic [DW-1:0]   rdata,
  output logic [2:0]      rvalid,
  output logic            protocol_err
);

  typedef enum logic [1:0] {IDLE, GRANT, SWITCH} state_t;

  state_t      state, state_next;
  logic [1:0]  owner, owner_next;
  logic [1:0]  last_owner, last_next;
  logic [15:0] hold_cnt, hold_next;

  logic [1:0]  arb_last;
  logic [1:0]  cand;
  logic [1:0]  pick_idx;
  logic        pick_found;
  logic        owner_req;
  logic        others_req;
  logic        preempt;

  // Handshake: req[i] is a level held until the requester is done; gnt[i] is the
  // registered permission, and SRAM ports follow the owner only while gnt is high.
  always_comb begin
    gnt = 3'b000;
    if (state == GRANT) begin
      case (owner)
        2'd0:    gnt = 3'b001;
        2'd1:    gnt = 3'b010;
        2'd2:    gnt = 3'b100;
        default: gnt = 3'b000;
      endcase
    end
  end

  // In SWITCH the outgoing owner already counts as the last owner for arbitration.
  assign arb_last = (state == SWITCH) ? owner : last_owner;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    cand       = arb_last;
    for (int j = 0; j < 3; j++) begin
      cand = (cand >= 2'd2) ? 2'd0 : cand + 2'd1;
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign owner_req  = |(req & gnt);
  assign others_req = |(req & ~gnt);
  assign preempt    = (MAX_HOLD != 16'd0) && (hold_cnt == MAX_HOLD - 16'd1) && others_req;

  always_comb begin
    state_next = state;
    owner_next = owner;
    last_next  = last_owner;
    hold_next  = hold_cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next = GRANT;
          owner_next = pick_idx;
          hold_next  = 16'd0;
        end
      end
      GRANT: begin
        hold_next = (hold_cnt == 16'hFFFF) ? hold_cnt : hold_cnt + 16'd1;
        if (!owner_req || preempt) state_next = SWITCH;
      end
      SWITCH: begin
        last_next = owner;
        hold_next = 16'd0;
        if (pick_found) begin
          state_next = GRANT;
          owner_next = pick_idx;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      owner        <= 2'd0;
      last_owner   <= 2'd2;
      hold_cnt     <= 16'd0;
      rvalid       <= 3'b000;
      protocol_err <= 1'b0;
    end else begin
      state        <= state_next;
      owner        <= owner_next;
      last_owner   <= last_next;
      hold_cnt     <= hold_next;
      rvalid       <= gnt;
      protocol_err <= protocol_err | (|(wr_en_in & ~gnt));
    end
  end

  // Only the owner's lanes are muxed through; everything is zero without a grant.
  always_comb begin
    sram_raddr     = '0;
    sram_waddr     = '0;
    sram_wdata     = '0;
    sram_wr_enable = |(wr_en_in & gnt);
    for (int i = 0; i < 3; i++) begin
      if (gnt[i]) begin
        sram_raddr = raddr_in[i*AW +: AW];
        sram_waddr = waddr_in[i*AW +: AW];
        sram_wdata = wdata_in[i*DW +: DW];
      end
    end
  end

  assign rdata = sram_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: two instances (MAX_HOLD=4 and MAX_HOLD=0) share stimulus and
// are checked every cycle against an owner/queue model plus directed literal scenarios.
module tb_sram_arbiter;
  localparam int AW = 6;
  localparam int DW = 8;
  localparam int RW = 3 * AW;
  localparam int DWW = 3 * DW;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [2:0]     req = '0;
  logic [2:0]     wr_en_in = '0;
  logic [RW-1:0]  raddr_in = '0;
  logic [RW-1:0]  waddr_in = '0;
  logic [DWW-1:0] wdata_in = '0;
  logic [DW-1:0]  sram_rdata = '0;

  logic [2:0]    gnt [2];
  logic [2:0]    rvalid [2];
  logic [AW-1:0] sram_raddr [2];
  logic [AW-1:0] sram_waddr [2];
  logic [DW-1:0] sram_wdata [2];
  logic [DW-1:0] rdata [2];
  logic          sram_wr_enable [2];
  logic          protocol_err [2];

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];

  sram_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(16'd4)) dut_a (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt[0]),
    .raddr_in(raddr_in), .waddr_in(waddr_in), .wdata_in(wdata_in), .wr_en_in(wr_en_in),
    .sram_raddr(sram_raddr[0]), .sram_waddr(sram_waddr[0]), .sram_wdata(sram_wdata[0]),
    .sram_wr_enable(sram_wr_enable[0]), .sram_rdata(sram_rdata), .rdata(rdata[0]),
    .rvalid(rvalid[0]), .protocol_err(protocol_err[0])
  );

  sram_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(16'd0)) dut_b (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt[1]),
    .raddr_in(raddr_in), .waddr_in(waddr_in), .wdata_in(wdata_in), .wr_en_in(wr_en_in),
    .sram_raddr(sram_raddr[1]), .sram_waddr(sram_waddr[1]), .sram_wdata(sram_wdata[1]),
    .sram_wr_enable(sram_wr_enable[1]), .sram_rdata(sram_rdata), .rdata(rdata[1]),
    .rvalid(rvalid[1]), .protocol_err(protocol_err[1])
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the SRAM, who owned it last, how long it has held it.
  int         m_owner [2] = '{-1, -1};
  int         m_last  [2] = '{2, 2};
  int         m_hold  [2] = '{0, 0};
  logic       m_err   [2] = '{1'b0, 1'b0};
  logic [2:0] m_rv    [2] = '{3'b000, 3'b000};
  int         m_max   [2] = '{4, 0};

  function automatic logic [2:0] model_gnt(input int k);
    return (m_owner[k] >= 0) ? 3'(1 << m_owner[k]) : 3'b000;
  endfunction

  task automatic model_reset(input int k);
    m_owner[k] = -1;
    m_last[k]  = 2;
    m_hold[k]  = 0;
    m_err[k]   = 1'b0;
    m_rv[k]    = 3'b000;
  endtask

  task automatic model_edge(input int k);
    logic [2:0] g;
    bit found;
    int c;
    g = model_gnt(k);
    if ((wr_en_in & ~g) != 3'b000) m_err[k] = 1'b1;
    m_rv[k] = g;
    if (m_owner[k] >= 0) begin
      if (!req[m_owner[k]] ||
          (m_max[k] != 0 && m_hold[k] == m_max[k] - 1 && (req & ~g) != 3'b000)) begin
        m_last[k]  = m_owner[k];
        m_owner[k] = -1;
      end else if (m_hold[k] < 65535) begin
        m_hold[k]++;
      end
    end else begin
      found = 1'b0;
      for (int j = 1; j <= 3; j++) begin
        c = (m_last[k] + j) % 3;
        if (!found && req[c]) begin
          found      = 1'b1;
          m_owner[k] = c;
          m_hold[k]  = 0;
        end
      end
    end
  endtask

  // Compare process: outputs checked on the falling edge, then the model takes the rising edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [2:0] eg;
      int o;
      if (!reset) model_reset(k);
      eg = model_gnt(k);
      o  = m_owner[k];
      check($sformatf("dut%0d gnt", k), 32'(gnt[k]), 32'(eg));
      check($sformatf("dut%0d rvalid", k), 32'(rvalid[k]), 32'(m_rv[k]));
      check($sformatf("dut%0d protocol_err", k), 32'(protocol_err[k]), 32'(m_err[k]));
      check($sformatf("dut%0d sram_raddr", k), 32'(sram_raddr[k]),
            (o >= 0) ? 32'(raddr_in[o*AW +: AW]) : 32'd0);
      check($sformatf("dut%0d sram_waddr", k), 32'(sram_waddr[k]),
            (o >= 0) ? 32'(waddr_in[o*AW +: AW]) : 32'd0);
      check($sformatf("dut%0d sram_wdata", k), 32'(sram_wdata[k]),
            (o >= 0) ? 32'(wdata_in[o*DW +: DW]) : 32'd0);
      check($sformatf("dut%0d sram_wr_enable", k), 32'(sram_wr_enable[k]),
            32'(|(wr_en_in & eg)));
      check($sformatf("dut%0d rdata", k), 32'(rdata[k]), 32'(sram_rdata));
      if (reset) model_edge(k);
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    req      = 3'b000;
    wr_en_in = 3'b000;
    repeat (2) step();
    reset = 1'b1;
  endtask

  logic [2:0] seq_exp [13] = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b010,
                               3'b000, 3'b100, 3'b100, 3'b100, 3'b000, 3'b001};
  logic [2:0] seq_req [13] = '{3'b111, 3'b111, 3'b110, 3'b111, 3'b111, 3'b111, 3'b101,
                               3'b111, 3'b111, 3'b111, 3'b011, 3'b111, 3'b111};
  logic [2:0] pre_exp [8]  = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b100, 3'b000, 3'b001};
  logic [2:0] pre_req [8]  = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b001, 3'b001, 3'b001};

  initial begin
    logic [2:0] e;
    bit held_ok;

    do_reset();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset dut%0d gnt", k), 32'(gnt[k]), 32'd0);
      check($sformatf("reset dut%0d protocol_err", k), 32'(protocol_err[k]), 32'd0);
    end

    // Single requester: one-edge grant latency, one more edge for rvalid.
    raddr_in = {6'd33, 6'd22, 6'd11};
    req = 3'b010;
    step();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("lat dut%0d gnt", k), 32'(gnt[k]), 32'(3'b010));
      check($sformatf("lat dut%0d sram_raddr", k), 32'(sram_raddr[k]), 32'd22);
      check($sformatf("lat dut%0d rvalid0", k), 32'(rvalid[k]), 32'd0);
    end
    step();
    for (int k = 0; k < 2; k++)
      check($sformatf("lat dut%0d rvalid1", k), 32'(rvalid[k]), 32'(3'b010));

    // Round robin with each owner dropping after three cycles.
    do_reset();
    foreach (seq_exp[i]) exp_q.push_back(seq_exp[i]);
    req = 3'b111;
    for (int i = 0; i < 13; i++) begin
      step();
      e = exp_q.pop_front();
      for (int k = 0; k < 2; k++)
        check($sformatf("rr dut%0d edge%0d", k, i + 1), 32'(gnt[k]), 32'(e));
      req = seq_req[i];
    end

    // Forced preemption on the MAX_HOLD=4 instance only.
    do_reset();
    req = 3'b001;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("preempt dut0 edge%0d", i + 1), 32'(gnt[0]), 32'(pre_exp[i]));
      check($sformatf("preempt dut1 edge%0d", i + 1), 32'(gnt[1]), 32'(3'b001));
      req = pre_req[i];
    end

    // MAX_HOLD=0: owner 1 keeps the grant while requester 0 waits.
    do_reset();
    req = 3'b010;
    step();
    req = 3'b011;
    held_ok = 1'b1;
    repeat (200) begin
      step();
      if (gnt[1] != 3'b010) held_ok = 1'b0;
    end
    check("nohold dut1 held 200", 32'(held_ok), 32'd1);
    req = 3'b001;
    step();
    check("nohold dut1 dead cycle", 32'(gnt[1]), 32'd0);
    step();
    check("nohold dut1 regrant", 32'(gnt[1]), 32'(3'b001));

    // Write without grant sets the sticky error.
    do_reset();
    req = 3'b001;
    step();
    wr_en_in = 3'b100;
    #1;
    check("werr dut0 wr_enable", 32'(sram_wr_enable[0]), 32'd0);
    step();
    check("werr dut0 protocol_err", 32'(protocol_err[0]), 32'd1);
    wr_en_in = 3'b000;
    req = 3'b000;
    repeat (5) step();
    check("werr dut0 sticky", 32'(protocol_err[0]), 32'd1);

    // Asynchronous reset in the middle of a write.
    req = 3'b001;
    step();
    wr_en_in = 3'b001;
    #1;
    check("areset dut0 wr_enable before", 32'(sram_wr_enable[0]), 32'd1);
    reset = 1'b0;
    #1;
    check("areset dut0 gnt", 32'(gnt[0]), 32'd0);
    check("areset dut0 wr_enable", 32'(sram_wr_enable[0]), 32'd0);
    check("areset dut0 protocol_err", 32'(protocol_err[0]), 32'd0);
    wr_en_in = 3'b000;
    step();
    reset = 1'b1;
    step();
    check("areset dut0 regrant", 32'(gnt[0]), 32'(3'b001));

    // Randomized traffic with occasional writes and resets.
    for (int n = 0; n < 3000; n++) begin
      step();
      reset = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 9) < 3) req = 3'($urandom_range(0, 7));
      wr_en_in   = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7)) : (req & gnt[0]);
      raddr_in   = RW'($urandom);
      waddr_in   = RW'($urandom);
      wdata_in   = DWW'($urandom);
      sram_rdata = DW'($urandom);
    end
    reset = 1'b1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 18, SRAM address width.
REQ-002 SHALL have parameter DW, default 16, SRAM data width.
REQ-003 SHALL have parameter MAX_HOLD, default 64, 16-bit, maximum grant cycles while others wait; 0 disables preemption.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req, input, 3, per-requester access request.
REQ-007 SHALL have port gnt, output, 3, registered one-hot grant (all-zero when none).
REQ-008 SHALL have ports raddr_in/waddr_in, input, 3*AW, requester i in bits [i*AW +: AW].
REQ-009 SHALL have ports wdata_in (3*DW) and wr_en_in (3), both inputs, per-requester write data and write enable.
REQ-010 SHALL have outputs sram_raddr (AW), sram_waddr (AW), sram_wdata (DW) and sram_wr_enable (1), driving the shared SRAM.
REQ-011 SHALL have ports sram_rdata (input, DW) and rdata (output, DW), rdata a direct pass-through.
REQ-012 SHALL have port rvalid, output, 3, rdata valid for requester i.
REQ-013 SHALL have port protocol_err, output, 1, sticky write-without-grant flag.

Function
REQ-014 SHALL implement FSM IDLE, GRANT, SWITCH; owner index and last-owner register held internally.
REQ-015 IDLE: any req high -> gnt set to first requester after last-owner in order 0,1,2 (wrapping), state GRANT; req at edge t gives gnt visible after edge t+1.
REQ-016 GRANT: SRAM outputs combinationally select owner's raddr/waddr/wdata/wr_en; non-owner inputs SHALL never reach SRAM.
REQ-017 GRANT: hold counter starts at 0 on grant, increments each GRANT cycle, saturates at 16'hFFFF.
REQ-018 GRANT -> SWITCH when req[owner] low.
REQ-019 GRANT -> SWITCH when MAX_HOLD!=0, hold counter == MAX_HOLD-1 and any other req high (forced preemption); owner keeps gnt exactly MAX_HOLD cycles.
REQ-020 Owner drop and preemption in same cycle SHALL behave as owner drop (single SWITCH).
REQ-021 With no other requester, owner SHALL keep gnt indefinitely regardless of MAX_HOLD.
REQ-022 SWITCH: gnt=0, SRAM outputs 0, last-owner updated to outgoing owner; arbitration per REQ-015 -> GRANT if any req, else IDLE; exactly one dead cycle between owners.
REQ-023 Preempted owner still requesting SHALL re-arbitrate with lowest priority.
REQ-024 No gnt: sram_raddr, sram_waddr, sram_wdata = 0, sram_wr_enable = 0.
REQ-025 rvalid[i] SHALL equal gnt[i] delayed one cycle (one-cycle SRAM read latency).
REQ-026 protocol_err SHALL set on any edge where wr_en_in[i] high and gnt[i] low; cleared only by reset.

Reset
REQ-027 reset low SHALL immediately, without clock: state IDLE, gnt=0, rvalid=0, hold counter 0, protocol_err 0, last-owner=2 (requester 0 first priority), all SRAM outputs 0.
REQ-028 Reset mid-grant SHALL abort the grant; in-flight write not completed; after release arbitration restarts from IDLE.
REQ-029 First clock edge after reset release SHALL perform normal IDLE arbitration.

Verification
REQ-030 After reset, req=3'b010 at edge 0 -> gnt=3'b010 after edge 1, sram_raddr=raddr_in[1], rvalid=3'b010 after edge 2.
REQ-031 req=3'b111 held, each requester dropping req 3 cycles after grant -> gnt sequence 001,000,010,000,100,000,001.
REQ-032 MAX_HOLD=4, req0 held, req2 raised mid-grant -> gnt=001 exactly 4 cycles, 000 one cycle, then 100; req0 re-granted after req2 drops.
REQ-033 gnt=001, wr_en_in=3'b100 -> sram_wr_enable=0, protocol_err=1 after next edge, stays 1 until reset.
REQ-034 reset low mid-GRANT with wr_en_in[0]=1 -> gnt=0, sram_wr_enable=0 without clock edge; after release req0 re-granted one edge later.
REQ-035 MAX_HOLD=0, req1 held 200 cycles with req0 waiting -> gnt stays 010 until req1 drops.
